// File: rtl/ctc_lane_deskew.sv
// Multi-lane deskew buffer. Every lane is written into its own circular buffer
// through a shared write pointer. Each lane is read through its own read pointer,
// anchored on that lane's COM symbol, so every output column holds symbols that
// were transmitted together. Also measures skew, flags misalignment, and has a
// registered bypass path.
module ctc_lane_deskew #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  input  logic                   deskew_enable,
  input  logic [8*NUM_LANES-1:0] data_in,
  input  logic [NUM_LANES-1:0]   kcntl_in,
  input  logic [NUM_LANES-1:0]   lanesync_in,
  output logic [8*NUM_LANES-1:0] deskew_data_out,
  output logic [NUM_LANES-1:0]   deskew_kcntl_out,
  output logic                   deskew_valid,
  output logic                   deskew_aligned,
  output logic                   deskew_error,
  output logic [ADDR_W-1:0]      deskew_skew
);

  localparam logic [7:0]        ComSym  = 8'hBC;
  // Last counter value at which a still-missing lane can be tolerated.
  localparam logic [ADDR_W-1:0] SkewMax = ADDR_W'(DEPTH - 2);

  typedef enum logic [1:0] {StIdle, StHunt, StAligned} state_e;

  state_e                           state_q, state_d;
  logic [ADDR_W-1:0]                wr_ptr_q;
  logic [NUM_LANES-1:0][ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [NUM_LANES-1:0][ADDR_W-1:0] com_ptr_q, com_ptr_d;
  logic [NUM_LANES-1:0]             com_seen_q, com_seen_d;
  logic [ADDR_W-1:0]                cnt_q, cnt_d;
  logic [ADDR_W-1:0]                skew_q, skew_d;
  logic [8*NUM_LANES-1:0]           data_q, data_d;
  logic [NUM_LANES-1:0]             kcntl_q, kcntl_d;
  logic                             valid_q, valid_d;
  logic                             aligned_q, aligned_d;
  logic                             error_q, error_d;

  logic [8:0]                       mem_q [NUM_LANES][DEPTH];
  logic [NUM_LANES-1:0][8:0]        rd_col;
  logic [NUM_LANES-1:0]             rd_com;
  logic [NUM_LANES-1:0]             in_com;
  logic [NUM_LANES-1:0]             seen_now;
  logic                             sync_all;
  logic                             misalign;

  assign sync_all = &lanesync_in;
  // A read column is consistent only if it holds COM on no lane or on every lane.
  assign misalign = (|rd_com) && !(&rd_com);
  assign seen_now = com_seen_q | in_com;

  // Buffer write: every lane, every cycle, regardless of state.
  always_ff @(posedge clk_in) begin
    for (int n = 0; n < NUM_LANES; n++) begin
      mem_q[n][wr_ptr_q] <= {kcntl_in[n], data_in[8*n +: 8]};
    end
  end

  // Read column at each lane's read pointer, and COM detection on the inputs.
  always_comb begin
    rd_col = '0;
    rd_com = '0;
    in_com = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      rd_col[n] = mem_q[n][rd_ptr_q[n]];
      rd_com[n] = rd_col[n][8] && (rd_col[n][7:0] == ComSym);
      in_com[n] = kcntl_in[n] && (data_in[8*n +: 8] == ComSym);
    end
  end

  // Next-state logic: hunt for COM on every lane, then track it.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    com_ptr_d  = com_ptr_q;
    com_seen_d = com_seen_q;
    cnt_d      = cnt_q;
    skew_d     = skew_q;
    error_d    = 1'b0;
    if (!deskew_enable || !sync_all) begin
      state_d    = StIdle;
      com_seen_d = '0;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d    = StHunt;
          com_seen_d = '0;
          cnt_d      = '0;
        end
        StHunt: begin
          // Only the first COM of each lane marks its anchor.
          for (int n = 0; n < NUM_LANES; n++) begin
            if (in_com[n] && !com_seen_q[n]) com_ptr_d[n] = wr_ptr_q;
          end
          com_seen_d = seen_now;
          if (&seen_now) begin
            for (int n = 0; n < NUM_LANES; n++) rd_ptr_d[n] = com_ptr_d[n];
            skew_d     = cnt_q;
            state_d    = StAligned;
            com_seen_d = '0;
            cnt_d      = '0;
          end else if (|seen_now) begin
            if (cnt_q == SkewMax) begin
              // Any further wait would let the earliest COM be overwritten.
              error_d    = 1'b1;
              com_seen_d = '0;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        StAligned: begin
          for (int n = 0; n < NUM_LANES; n++) rd_ptr_d[n] = rd_ptr_q[n] + 1'b1;
          com_seen_d = '0;
          cnt_d      = '0;
          if (misalign) begin
            error_d = 1'b1;
            state_d = StHunt;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output next values: bypass pass-through, or the aligned read column.
  always_comb begin
    data_d    = '0;
    kcntl_d   = '0;
    valid_d   = 1'b0;
    aligned_d = deskew_enable && (state_d == StAligned);
    if (!deskew_enable) begin
      data_d  = data_in;
      kcntl_d = kcntl_in;
      valid_d = sync_all;
    end else begin
      // Valid only while alignment holds across this edge.
      valid_d = (state_q == StAligned) && (state_d == StAligned);
      if (state_q == StAligned) begin
        for (int n = 0; n < NUM_LANES; n++) begin
          data_d[8*n +: 8] = rd_col[n][7:0];
          kcntl_d[n]       = rd_col[n][8];
        end
      end
    end
  end

  // State, pointer, and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      com_ptr_q  <= '0;
      com_seen_q <= '0;
      cnt_q      <= '0;
      skew_q     <= '0;
      data_q     <= '0;
      kcntl_q    <= '0;
      valid_q    <= 1'b0;
      aligned_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_q + 1'b1;
      rd_ptr_q   <= rd_ptr_d;
      com_ptr_q  <= com_ptr_d;
      com_seen_q <= com_seen_d;
      cnt_q      <= cnt_d;
      skew_q     <= skew_d;
      data_q     <= data_d;
      kcntl_q    <= kcntl_d;
      valid_q    <= valid_d;
      aligned_q  <= aligned_d;
      error_q    <= error_d;
    end
  end

  assign deskew_data_out  = data_q;
  assign deskew_kcntl_out = kcntl_q;
  assign deskew_valid     = valid_q;
  assign deskew_aligned   = aligned_q;
  assign deskew_error     = error_q;
  assign deskew_skew      = skew_q;

endmodule

// File: tb/tb_ctc_lane_deskew.sv
// Bench for ctc_lane_deskew. The transmitter produces a column stream with a
// COM column every 16 symbols. Each lane sees that stream delayed by its own
// skew. A cycle-indexed reference model recomputes every output from the
// input history.
module tb_ctc_lane_deskew;

  localparam int NL  = 4;
  localparam int DP  = 8;
  localparam int AW  = 3;
  localparam int TXN = 4096;

  logic            clk_in = 1'b0;
  logic            rst_n;
  logic            deskew_enable;
  logic [8*NL-1:0] data_in;
  logic [NL-1:0]   kcntl_in;
  logic [NL-1:0]   lanesync_in;
  logic [8*NL-1:0] deskew_data_out;
  logic [NL-1:0]   deskew_kcntl_out;
  logic            deskew_valid;
  logic            deskew_aligned;
  logic            deskew_error;
  logic [AW-1:0]   deskew_skew;

  ctc_lane_deskew #(.NUM_LANES(NL), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk_in           (clk_in),
    .rst_n            (rst_n),
    .deskew_enable    (deskew_enable),
    .data_in          (data_in),
    .kcntl_in         (kcntl_in),
    .lanesync_in      (lanesync_in),
    .deskew_data_out  (deskew_data_out),
    .deskew_kcntl_out (deskew_kcntl_out),
    .deskew_valid     (deskew_valid),
    .deskew_aligned   (deskew_aligned),
    .deskew_error     (deskew_error),
    .deskew_skew      (deskew_skew)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ref_idx  = 100;
  int skew [NL];

  logic [7:0] tx_d [TXN][NL];
  logic       tx_k [TXN][NL];
  logic [8:0] hist [TXN][NL];

  // Reference model: 0 idle, 1 hunting, 2 aligned.
  int              mst = 0;
  bit              seen [NL];
  int              seen_cyc [NL];
  int              src [NL];
  logic [8*NL-1:0] e_data;
  logic [NL-1:0]   e_k;
  logic            e_valid, e_aligned, e_error, e_chk_data;
  logic [AW-1:0]   e_skew = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply_lanes();
    for (int n = 0; n < NL; n++) begin
      int idx;
      idx = (ref_idx - skew[n]) % TXN;
      data_in[8*n +: 8] = tx_d[idx][n];
      kcntl_in[n]       = tx_k[idx][n];
    end
  endtask

  task automatic clear_seen();
    for (int n = 0; n < NL; n++) seen[n] = 1'b0;
  endtask

  task automatic model_update();
    int nseen, t0, ncom;
    cyc++;
    for (int n = 0; n < NL; n++) hist[cyc % TXN][n] = {kcntl_in[n], data_in[8*n +: 8]};
    e_error    = 1'b0;
    e_valid    = 1'b0;
    e_aligned  = 1'b0;
    e_chk_data = 1'b0;
    if (!rst_n) begin
      mst = 0; clear_seen();
      e_data = '0; e_k = '0; e_skew = '0; e_chk_data = 1'b1;
      return;
    end
    if (!deskew_enable) begin
      mst = 0; clear_seen();
      e_data = data_in; e_k = kcntl_in; e_valid = &lanesync_in; e_chk_data = 1'b1;
      return;
    end
    if (!(&lanesync_in)) begin
      mst = 0; clear_seen();
      return;
    end
    case (mst)
      0: begin mst = 1; clear_seen(); end
      1: begin
        nseen = 0; t0 = cyc;
        for (int n = 0; n < NL; n++) begin
          if (!seen[n] && kcntl_in[n] && data_in[8*n +: 8] == 8'hBC) begin
            seen[n] = 1'b1; seen_cyc[n] = cyc;
          end
          if (seen[n]) begin
            nseen++;
            if (seen_cyc[n] < t0) t0 = seen_cyc[n];
          end
        end
        if (nseen == NL) begin
          e_skew = AW'(cyc - t0);
          for (int n = 0; n < NL; n++) src[n] = seen_cyc[n];
          mst = 2; e_aligned = 1'b1; clear_seen();
        end else if (nseen > 0 && cyc - t0 == DP - 2) begin
          e_error = 1'b1; clear_seen();
        end
      end
      default: begin
        ncom = 0;
        for (int n = 0; n < NL; n++) begin
          logic [8:0] s;
          s = hist[src[n] % TXN][n];
          src[n]++;
          e_data[8*n +: 8] = s[7:0];
          e_k[n]           = s[8];
          if (s[8] && s[7:0] == 8'hBC) ncom++;
        end
        if (ncom != 0 && ncom != NL) begin
          e_error = 1'b1; mst = 1; clear_seen();
        end else begin
          e_valid = 1'b1; e_aligned = 1'b1; e_chk_data = 1'b1;
        end
      end
    endcase
  endtask

  task automatic compare_outputs();
    check("valid",   32'(deskew_valid),   32'(e_valid));
    check("aligned", 32'(deskew_aligned), 32'(e_aligned));
    check("error",   32'(deskew_error),   32'(e_error));
    check("skew",    32'(deskew_skew),    32'(e_skew));
    if (e_chk_data) begin
      check("data",  32'(deskew_data_out),  32'(e_data));
      check("kcntl", 32'(deskew_kcntl_out), 32'(e_k));
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    model_update();
    compare_outputs();
    ref_idx++;
    apply_lanes();
  endtask

  // Re-enter hunting with lane 0 three symbols ahead of its next COM.
  task automatic restart_hunt(input int s0, input int s1, input int s2, input int s3);
    deskew_enable = 1'b0;
    step();
    skew[0] = s0; skew[1] = s1; skew[2] = s2; skew[3] = s3;
    ref_idx = ((ref_idx / 16) + 2) * 16 - 3;
    deskew_enable = 1'b1;
    apply_lanes();
  endtask

  initial begin
    int errs, alns;
    bit hit;
    logic [8*NL-1:0] prev_d;
    logic [NL-1:0]   prev_k;

    for (int i = 0; i < TXN; i++) begin
      for (int n = 0; n < NL; n++) begin
        if (i % 16 == 0) begin
          tx_d[i][n] = 8'hBC; tx_k[i][n] = 1'b1;
        end else begin
          tx_d[i][n] = 8'($urandom);
          if (tx_d[i][n] == 8'hBC) tx_d[i][n] = 8'h1C;
          tx_k[i][n] = ($urandom_range(7) == 0);
        end
      end
    end
    for (int n = 0; n < NL; n++) begin skew[n] = 0; seen[n] = 1'b0; seen_cyc[n] = 0; src[n] = 0; end

    // Reset with random inputs.
    rst_n = 1'b0; deskew_enable = 1'b1; lanesync_in = 4'hF;
    data_in = $urandom; kcntl_in = 4'($urandom);
    for (int i = 0; i < 3; i++) begin
      step();
      data_in = $urandom; kcntl_in = 4'($urandom); lanesync_in = 4'($urandom);
    end
    check("rst_data",    32'(deskew_data_out), 32'h0);
    check("rst_valid",   32'(deskew_valid),    32'h0);
    check("rst_aligned", 32'(deskew_aligned),  32'h0);
    check("rst_skew",    32'(deskew_skew),     32'h0);

    // Zero skew: COM on all lanes on the 4th edge after release.
    rst_n = 1'b1; lanesync_in = 4'hF; ref_idx = 157; apply_lanes();
    for (int i = 0; i < 4; i++) step();
    check("zs_aligned",       32'(deskew_aligned), 32'h1);
    check("zs_model_aligned", 32'(e_aligned),      32'h1);
    step();
    check("zs_col",   32'(deskew_data_out),  32'hBCBCBCBC);
    check("zs_k",     32'(deskew_kcntl_out), 32'hF);
    check("zs_valid", 32'(deskew_valid),     32'h1);
    check("zs_skew",  32'(deskew_skew),      32'h0);
    for (int i = 0; i < 30; i++) step();

    // Skew 0/2/5/6: lane 3 COM arrives 9 edges after the hunt starts.
    restart_hunt(0, 2, 5, 6);
    for (int i = 0; i < 10; i++) step();
    check("sk6_aligned",    32'(deskew_aligned), 32'h1);
    check("sk6_skew",       32'(deskew_skew),    32'h6);
    check("sk6_model_skew", 32'(e_skew),         32'h6);
    step();
    check("sk6_col",   32'(deskew_data_out),  32'hBCBCBCBC);
    check("sk6_k",     32'(deskew_kcntl_out), 32'hF);
    check("sk6_valid", 32'(deskew_valid),     32'h1);
    for (int i = 0; i < 40; i++) step();

    // Skew 7 overruns the window; then skew 3 aligns.
    restart_hunt(0, 2, 5, 7);
    errs = 0; alns = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (deskew_error) errs++;
      if (deskew_aligned) alns++;
    end
    check("sk7_error_seen", 32'(errs > 0), 32'h1);
    check("sk7_never_aln",  32'(alns),     32'h0);
    skew[0] = 0; skew[1] = 1; skew[2] = 2; skew[3] = 3; apply_lanes();
    for (int i = 0; i < 40; i++) step();
    check("sk3_aligned", 32'(deskew_aligned), 32'h1);

    // Extra symbol on lane 2 mid-frame.
    while (ref_idx % 16 != 8) step();
    skew[2] = skew[2] + 1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (deskew_error) hit = 1'b1;
    end
    check("ins_error_seen", 32'(hit),            32'h1);
    check("ins_valid",      32'(deskew_valid),   32'h0);
    check("ins_aligned",    32'(deskew_aligned), 32'h0);
    for (int i = 0; i < 40; i++) step();
    check("ins_realigned", 32'(deskew_aligned), 32'h1);

    // Lane sync drop while aligned.
    lanesync_in = 4'b1101;
    step();
    check("sync_valid",   32'(deskew_valid),   32'h0);
    check("sync_aligned", 32'(deskew_aligned), 32'h0);
    lanesync_in = 4'hF;
    for (int i = 0; i < 40; i++) step();

    // Bypass: one-cycle registered pass-through.
    deskew_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data_in = $urandom; kcntl_in = 4'($urandom);
      prev_d = data_in; prev_k = kcntl_in;
      step();
      check("byp_data",    32'(deskew_data_out),  32'(prev_d));
      check("byp_k",       32'(deskew_kcntl_out), 32'(prev_k));
      check("byp_aligned", 32'(deskew_aligned),   32'h0);
    end
    deskew_enable = 1'b1; apply_lanes();

    // Randomized mix of skews, slips, sync drops, mode changes, resets.
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(199);
      if (r < 3) deskew_enable = ~deskew_enable;
      else if (r < 6) lanesync_in = 4'($urandom);
      else if (r < 12) lanesync_in = 4'hF;
      else if (r < 15) begin
        for (int n = 0; n < NL; n++) skew[n] = ($urandom_range(9) == 0) ? 7 : $urandom_range(6);
      end else if (r < 19) begin
        int n;
        n = $urandom_range(NL - 1);
        if ($urandom_range(1) == 0) begin
          if (skew[n] < 7) skew[n] = skew[n] + 1;
        end else if (skew[n] > 0) skew[n] = skew[n] - 1;
      end else if (r == 199) begin
        rst_n = 1'b0;
      end
      if (r < 100 && !deskew_enable && $urandom_range(3) == 0) deskew_enable = 1'b1;
      apply_lanes();
      step();
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
